pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder.sv | 127 ++++++++++++
 tb/tb_pipelined_adder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Ripple-carry adder/subtractor split into STAGES chunk-wide pipeline stages with
// valid/ready handshaking on both sides and per-stage bubble collapsing.
module pipelined_adder #(
    parameter int unsigned XLEN   = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            carry_in,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] sum,
    output logic            carry_out,
    output logic            overflow,
    output logic            zero
);

    localparam int unsigned W    = XLEN / STAGES;
    localparam int unsigned CW   = W + 1;
    localparam int unsigned LAST = STAGES - 1;

    if ((STAGES == 0) || ((XLEN % STAGES) != 0)) begin : g_bad_param
        $error("pipelined_adder: XLEN must be a non-zero multiple of STAGES");
    end

    // Stage registers: operands travel with the transaction, sum fills in chunk by chunk
    logic            r_valid [STAGES];
    logic [XLEN-1:0] r_a     [STAGES];
    logic [XLEN-1:0] r_b     [STAGES];
    logic [XLEN-1:0] r_sum   [STAGES];
    logic            r_cy    [STAGES];
    logic            r_ovf;
    logic            r_zero;

    logic            w_ready     [STAGES];
    logic            w_src_valid [STAGES];
    logic [XLEN-1:0] w_src_a     [STAGES];
    logic [XLEN-1:0] w_src_b     [STAGES];
    logic [XLEN-1:0] w_src_sum   [STAGES];
    logic            w_src_cy    [STAGES];
    logic [XLEN-1:0] w_nxt_sum   [STAGES];
    logic            w_nxt_cy    [STAGES];
    logic            w_ovf;
    logic            w_zero;

    // A stage can load when it is empty or everything downstream can move
    always_comb begin
        logic v_rdy;
        v_rdy = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            v_rdy      = !r_valid[k] || v_rdy;
            w_ready[k] = v_rdy;
        end
    end

    // Per-stage chunk add; stage 0 takes the inverted-b / forced-carry for subtract
    always_comb begin
        logic [CW-1:0] v_chunk;
        v_chunk        = '0;
        w_src_valid[0] = in_valid;
        w_src_a[0]     = a;
        w_src_b[0]     = sub ? ~b : b;
        w_src_sum[0]   = '0;
        w_src_cy[0]    = sub | carry_in;
        for (int k = 1; k < int'(STAGES); k++) begin
            w_src_valid[k] = r_valid[k-1];
            w_src_a[k]     = r_a[k-1];
            w_src_b[k]     = r_b[k-1];
            w_src_sum[k]   = r_sum[k-1];
            w_src_cy[k]    = r_cy[k-1];
        end
        for (int k = 0; k < int'(STAGES); k++) begin
            v_chunk = CW'(w_src_a[k][k*W +: W]) + CW'(w_src_b[k][k*W +: W])
                    + CW'(w_src_cy[k]);
            w_nxt_sum[k]            = w_src_sum[k];
            w_nxt_sum[k][k*W +: W]  = v_chunk[W-1:0];
            w_nxt_cy[k]             = v_chunk[W];
        end
        w_ovf  = (w_src_a[LAST][XLEN-1] == w_src_b[LAST][XLEN-1])
              && (w_nxt_sum[LAST][XLEN-1] != w_src_a[LAST][XLEN-1]);
        w_zero = (w_nxt_sum[LAST] == '0);
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        always_ff @(posedge clk) begin
            if (!rstn) begin
                r_valid[k] <= 1'b0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_sum[k]   <= '0;
                r_cy[k]    <= 1'b0;
            end else if (w_ready[k]) begin
                r_valid[k] <= w_src_valid[k];
                if (w_src_valid[k]) begin
                    r_a[k]   <= w_src_a[k];
                    r_b[k]   <= w_src_b[k];
                    r_sum[k] <= w_nxt_sum[k];
                    r_cy[k]  <= w_nxt_cy[k];
                end
            end
        end
    end

    // Flags derived from the complete result as it enters the final stage
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_ready[LAST] && w_src_valid[LAST]) begin
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
        end
    end

    assign in_ready  = w_ready[0];
    assign out_valid = r_valid[LAST];
    assign sum       = r_sum[LAST];
    assign carry_out = r_cy[LAST];
    assign overflow  = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed scoreboard bench for pipelined_adder: 16/4 main instance plus
// 32-bit instances with 1, 2 and 8 stages.
module tb_pipelined_adder;

    localparam int unsigned XLEN   = 16;
    localparam int unsigned STAGES = 4;

    typedef struct packed {
        logic [31:0] sum;
        logic        cy;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic            clk;
    logic            rstn;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            carry_in;
    logic            sub;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] sum;
    logic            carry_out;
    logic            overflow;
    logic            zero;

    logic            sw_valid;
    logic [31:0]     sw_a;
    logic [31:0]     sw_b;
    logic            sw_ci;
    logic            sw_sub;
    logic            sw_rdy [3];
    logic            sw_ov  [3];
    logic [31:0]     sw_sum [3];
    logic            sw_cy  [3];
    logic            sw_of  [3];
    logic            sw_z   [3];

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_pop = 0;
    exp_t sb_q[$];

    int   lat;
    int   n_gap;
    int   n_stale;
    int   pop0;
    logic acc;
    exp_t e_sw;
    int   sw_lat  [3];
    int   sw_seen [3];
    int   sw_st   [3];
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic        vc [5];
    logic        vs [5];

    pipelined_adder #(.XLEN(XLEN), .STAGES(STAGES)) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    for (genvar g = 0; g < 3; g++) begin : g_sw
        pipelined_adder #(.XLEN(32), .STAGES((g == 0) ? 1 : ((g == 1) ? 2 : 8))) u_sw (
            .clk       (clk),
            .rstn      (rstn),
            .in_valid  (sw_valid),
            .in_ready  (sw_rdy[g]),
            .a         (sw_a),
            .b         (sw_b),
            .carry_in  (sw_ci),
            .sub       (sw_sub),
            .out_valid (sw_ov[g]),
            .out_ready (1'b1),
            .sum       (sw_sum[g]),
            .carry_out (sw_cy[g]),
            .overflow  (sw_of[g]),
            .zero      (sw_z[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: unsigned sum for result/carry, exact signed arithmetic for overflow
    function automatic exp_t model(input logic [63:0] av, input logic [63:0] bv,
                                   input logic ci, input logic sb, input int w);
        logic [63:0] mask;
        logic [63:0] full;
        longint      sa;
        longint      sbv;
        longint      tru;
        longint      lim;
        exp_t        e;
        mask = (64'd1 << w) - 64'd1;
        if (sb) full = (av & mask) + (~bv & mask) + 64'd1;
        else    full = (av & mask) + (bv & mask) + 64'(ci);
        lim  = longint'(64'd1 << (w - 1));
        sa   = av[w-1] ? longint'(av & mask) - 2 * lim : longint'(av & mask);
        sbv  = bv[w-1] ? longint'(bv & mask) - 2 * lim : longint'(bv & mask);
        tru  = sb ? sa - sbv : sa + sbv + longint'(ci);
        e.sum  = 32'(full & mask);
        e.cy   = full[w];
        e.ovf  = (tru >= lim) || (tru < -lim);
        e.zero = ((full & mask) == 64'd0);
        return e;
    endfunction

    // Scoreboard: push on accepted input, pop/compare on accepted output
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_output", 64'(out_valid), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    n_pop++;
                    chk("sb_sum",       64'(sum),       64'(e.sum));
                    chk("sb_carry_out", 64'(carry_out), 64'(e.cy));
                    chk("sb_overflow",  64'(overflow),  64'(e.ovf));
                    chk("sb_zero",      64'(zero),      64'(e.zero));
                end
            end
            if (in_valid && in_ready)
                sb_q.push_back(model(64'(a), 64'(b), carry_in, sub, 16));
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb_q.size() != 0; k++) nxt();
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b1; a = 16'h1234; b = 16'h1111;
        carry_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sub = 1'b0;
        repeat (3) nxt();

        // Reset state; the operand offered during reset must never emerge
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_sum",       64'(sum),       64'd0);
        chk("rst_carry_out", 64'(carry_out), 64'd0);
        chk("rst_overflow",  64'(overflow),  64'd0);
        chk("rst_zero",      64'(zero),      64'd0);
        rstn = 1'b1; in_valid = 1'b0;
        nxt();

        // 0xFFFF + 1 wraps to zero with carry
        a = 16'hFFFF; b = 16'h0001; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        #1 chk("add_in_ready", 64'(in_ready), 64'd1);
        nxt();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin nxt(); lat++; end
        chk("add_latency",   64'(lat),       64'd4);
        chk("add_sum",       64'(sum),       64'h0000);
        chk("add_carry_out", 64'(carry_out), 64'd1);
        chk("add_zero",      64'(zero),      64'd1);
        chk("add_overflow",  64'(overflow),  64'd0);
        drain();

        // 0x8000 - 1 overflows to 0x7FFF
        a = 16'h8000; b = 16'h0001; carry_in = 1'b1; sub = 1'b1; in_valid = 1'b1;
        nxt();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin nxt(); lat++; end
        chk("sub_latency",   64'(lat),       64'd4);
        chk("sub_sum",       64'(sum),       64'h7FFF);
        chk("sub_carry_out", 64'(carry_out), 64'd1);
        chk("sub_overflow",  64'(overflow),  64'd1);
        chk("sub_zero",      64'(zero),      64'd0);
        drain();

        // 100 back-to-back operand sets; output must be continuous after fill
        pop0 = n_pop; n_gap = 0;
        for (int i = 0; i < 104; i++) begin
            if (i < 100) begin
                in_valid = 1'b1;
                a = 16'($urandom); b = 16'($urandom);
                carry_in = 1'($urandom); sub = 1'($urandom);
                if (i == 50) begin a = 16'h7FFF; b = 16'h0001; carry_in = 1'b0; sub = 1'b0; end
                if (i == 51) begin a = 16'h8000; b = 16'h8000; sub = 1'b0; end
                if (i == 52) begin a = 16'h1234; b = 16'h1234; sub = 1'b1; end
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i >= 4 && !out_valid) n_gap++;
            if (i < 100 && !in_ready) n_gap++;
            nxt();
        end
        drain();
        chk("stream_gaps",  64'(n_gap),        64'd0);
        chk("stream_count", 64'(n_pop - pop0), 64'd100);

        // Backpressure: fill 4 stages, then stall 10 more cycles
        pop0 = n_pop; out_ready = 1'b0; acc = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (acc) begin
                a = 16'($urandom); b = 16'($urandom);
                carry_in = 1'($urandom); sub = 1'($urandom);
            end
            in_valid = 1'b1;
            #1;
            chk("bp_in_ready",  64'(in_ready),  64'(c < 4));
            chk("bp_out_valid", 64'(out_valid), 64'(c >= 4));
            if (c >= 4) begin
                chk("bp_hold_sum",  64'(sum),       64'(sb_q[0].sum));
                chk("bp_hold_cy",   64'(carry_out), 64'(sb_q[0].cy));
                chk("bp_hold_ovf",  64'(overflow),  64'(sb_q[0].ovf));
                chk("bp_hold_zero", 64'(zero),      64'(sb_q[0].zero));
            end
            acc = in_ready;
            nxt();
        end
        out_ready = 1'b1; in_valid = 1'b0;
        drain();
        chk("bp_count", 64'(n_pop - pop0), 64'd4);

        // Reset with three transactions in flight
        for (int t = 0; t < 3; t++) begin
            a = 16'($urandom) | 16'h0101; b = 16'($urandom); carry_in = 1'b1; sub = 1'b0;
            in_valid = 1'b1;
            #1 chk("mr_in_ready", 64'(in_ready), 64'd1);
            nxt();
        end
        in_valid = 1'b0; rstn = 1'b0;
        nxt();
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_sum",       64'(sum),       64'd0);
        chk("mr_carry_out", 64'(carry_out), 64'd0);
        chk("mr_overflow",  64'(overflow),  64'd0);
        chk("mr_zero",      64'(zero),      64'd0);
        chk("mr_in_ready",  64'(in_ready),  64'd1);
        rstn = 1'b1; n_stale = 0;
        for (int k = 0; k < 10; k++) begin
            nxt();
            if (out_valid) n_stale++;
        end
        chk("mr_stale", 64'(n_stale), 64'd0);

        // 32-bit depth sweep: latency equals STAGES, results per model
        sw_st[0] = 1; sw_st[1] = 2; sw_st[2] = 8;
        va[0] = 32'h7FFFFFFF; vb[0] = 32'h00000001; vc[0] = 1'b1; vs[0] = 1'b0;
        va[1] = 32'hFFFFFFFF; vb[1] = 32'h00000001; vc[1] = 1'b0; vs[1] = 1'b0;
        va[2] = 32'h80000000; vb[2] = 32'h00000001; vc[2] = 1'b1; vs[2] = 1'b1;
        va[3] = 32'h12345678; vb[3] = 32'h9ABCDEF0; vc[3] = 1'b1; vs[3] = 1'b0;
        va[4] = 32'h00000000; vb[4] = 32'h80000000; vc[4] = 1'b0; vs[4] = 1'b1;
        for (int v = 0; v < 5; v++) begin
            sw_a = va[v]; sw_b = vb[v]; sw_ci = vc[v]; sw_sub = vs[v]; sw_valid = 1'b1;
            e_sw = model(64'(va[v]), 64'(vb[v]), vc[v], vs[v], 32);
            #1;
            for (int g = 0; g < 3; g++) chk("sw_in_ready", 64'(sw_rdy[g]), 64'd1);
            nxt();
            sw_valid = 1'b0;
            for (int g = 0; g < 3; g++) begin sw_lat[g] = 0; sw_seen[g] = 0; end
            for (int k = 1; k <= 12; k++) begin
                for (int g = 0; g < 3; g++) begin
                    if (sw_ov[g]) begin
                        if (sw_seen[g] == 0) begin
                            sw_lat[g] = k;
                            chk("sw_sum",       64'(sw_sum[g]), 64'(e_sw.sum));
                            chk("sw_carry_out", 64'(sw_cy[g]),  64'(e_sw.cy));
                            chk("sw_overflow",  64'(sw_of[g]),  64'(e_sw.ovf));
                            chk("sw_zero",      64'(sw_z[g]),   64'(e_sw.zero));
                        end
                        sw_seen[g]++;
                    end
                end
                nxt();
            end
            for (int g = 0; g < 3; g++) begin
                chk("sw_latency", 64'(sw_lat[g]),  64'(sw_st[g]));
                chk("sw_count",   64'(sw_seen[g]), 64'd1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
